my_mem_ctrl: RTL and testbench

Sequencer for the MEM stage's data-memory port. It accepts one load/store request at a time from the EX/MEM pipeline register, checks alignment, and drives a single-outstanding request/acknowledge bus to DRAM with byte-lane strobes and lane-replicated store data. It stalls the pipeline while the access is in flight and bounds every access with a timeout. On a load it captures the raw DRAM word and hands `sext2_op`/`addr` to the writeback-stage sign extender.

---
 rtl/my_mem_ctrl_if.sv | 41 ++++
 rtl/my_mem_ctrl.sv | 178 +++++++++++++++++
 tb/tb_my_mem_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/my_mem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : my_mem_ctrl_if
// Description : MEM-stage request, DRAM bus and load-result bundle for
//               my_mem_ctrl (master = controller side).
// Revision    : 1.0 - initial release
// ============================================================================
interface my_mem_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        bus_req;
    logic        bus_we;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        stall;
    logic        done;
    logic [31:0] ld_data;
    logic [1:0]  ld_sext_op;
    logic [1:0]  ld_addr;
    logic        misalign;
    logic        bus_err;

    modport master (
        input  mem_req, mem_we, mem_size, mem_addr, mem_wdata, bus_ack, bus_rdata,
        output bus_req, bus_we, bus_wstrb, bus_addr, bus_wdata,
        output stall, done, ld_data, ld_sext_op, ld_addr, misalign, bus_err
    );

    modport slave (
        output mem_req, mem_we, mem_size, mem_addr, mem_wdata, bus_ack, bus_rdata,
        input  bus_req, bus_we, bus_wstrb, bus_addr, bus_wdata,
        input  stall, done, ld_data, ld_sext_op, ld_addr, misalign, bus_err
    );
endinterface
`default_nettype wire

// File: rtl/my_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : my_mem_ctrl
// Description : MEM-stage data-memory sequencer: alignment check, single-
//               outstanding DRAM req/ack access with timeout, load capture.
// Revision    : 1.0 - initial release
// ============================================================================
module my_mem_ctrl #(
    parameter int TIMEOUT = 16
) (
    input wire logic     clk,
    input wire logic     rst,
    my_mem_ctrl_if.master mif
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_access = 2'd1;
    localparam logic [1:0] c_st_resp   = 2'd2;
    localparam logic [7:0] c_tmo_last  = 8'(TIMEOUT - 1);

    logic [1:0]  r_state,      w_state_nxt;
    logic [7:0]  r_cnt,        w_cnt_nxt;
    logic        r_lat_we,     w_lat_we_nxt;
    logic [1:0]  r_lat_size,   w_lat_size_nxt;
    logic [1:0]  r_lat_lo,     w_lat_lo_nxt;
    logic        r_bus_req,    w_bus_req_nxt;
    logic        r_bus_we,     w_bus_we_nxt;
    logic [3:0]  r_bus_wstrb,  w_bus_wstrb_nxt;
    logic [31:0] r_bus_addr,   w_bus_addr_nxt;
    logic [31:0] r_bus_wdata,  w_bus_wdata_nxt;
    logic        r_done,       w_done_nxt;
    logic        r_misalign,   w_misalign_nxt;
    logic        r_bus_err,    w_bus_err_nxt;
    logic [31:0] r_ld_data,    w_ld_data_nxt;
    logic [1:0]  r_ld_sext_op, w_ld_sext_op_nxt;
    logic [1:0]  r_ld_addr,    w_ld_addr_nxt;
    logic        w_aligned;
    logic [3:0]  w_strb;
    logic [31:0] w_wdata;

    always_comb begin
        w_aligned = 1'b0;
        w_strb    = 4'b0000;
        w_wdata   = mif.mem_wdata;
        case (mif.mem_size)
            2'b00: begin
                w_aligned = 1'b1;
                w_strb    = 4'b0001 << mif.mem_addr[1:0];
                w_wdata   = {4{mif.mem_wdata[7:0]}};
            end
            2'b01: begin
                w_aligned = ~mif.mem_addr[0];
                w_strb    = mif.mem_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata   = {2{mif.mem_wdata[15:0]}};
            end
            2'b10: begin
                w_aligned = (mif.mem_addr[1:0] == 2'b00);
                w_strb    = 4'b1111;
            end
            default: w_aligned = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_lat_we_nxt     = r_lat_we;
        w_lat_size_nxt   = r_lat_size;
        w_lat_lo_nxt     = r_lat_lo;
        w_bus_req_nxt    = r_bus_req;
        w_bus_we_nxt     = r_bus_we;
        w_bus_wstrb_nxt  = r_bus_wstrb;
        w_bus_addr_nxt   = r_bus_addr;
        w_bus_wdata_nxt  = r_bus_wdata;
        w_done_nxt       = 1'b0;
        w_misalign_nxt   = 1'b0;
        w_bus_err_nxt    = 1'b0;
        w_ld_data_nxt    = r_ld_data;
        w_ld_sext_op_nxt = r_ld_sext_op;
        w_ld_addr_nxt    = r_ld_addr;
        case (r_state)
            c_st_idle: begin
                if (mif.mem_req && w_aligned) begin
                    w_state_nxt     = c_st_access;
                    w_cnt_nxt       = 8'd0;
                    w_lat_we_nxt    = mif.mem_we;
                    w_lat_size_nxt  = mif.mem_size;
                    w_lat_lo_nxt    = mif.mem_addr[1:0];
                    w_bus_req_nxt   = 1'b1;
                    w_bus_we_nxt    = mif.mem_we;
                    w_bus_wstrb_nxt = mif.mem_we ? w_strb : 4'b0000;
                    w_bus_addr_nxt  = {mif.mem_addr[31:2], 2'b00};
                    w_bus_wdata_nxt = w_wdata;
                end else if (mif.mem_req) begin
                    w_misalign_nxt = 1'b1;
                end
            end
            c_st_access: begin
                if (mif.bus_ack) begin
                    w_state_nxt   = c_st_resp;
                    w_bus_req_nxt = 1'b0;
                    w_done_nxt    = 1'b1;
                    // Only loads update the extender inputs; stores leave them intact.
                    if (!r_lat_we) begin
                        w_ld_data_nxt    = mif.bus_rdata;
                        w_ld_addr_nxt    = r_lat_lo;
                        w_ld_sext_op_nxt = (r_lat_size == 2'b00) ? 2'b01 :
                                           (r_lat_size == 2'b01) ? 2'b10 : 2'b00;
                    end
                end else if (r_cnt == c_tmo_last) begin
                    w_state_nxt   = c_st_idle;
                    w_bus_req_nxt = 1'b0;
                    w_bus_err_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            c_st_resp: w_state_nxt = c_st_idle;
            default:   w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_cnt        <= 8'd0;
            r_lat_we     <= 1'b0;
            r_lat_size   <= 2'b00;
            r_lat_lo     <= 2'b00;
            r_bus_req    <= 1'b0;
            r_bus_we     <= 1'b0;
            r_bus_wstrb  <= 4'b0000;
            r_bus_addr   <= 32'd0;
            r_bus_wdata  <= 32'd0;
            r_done       <= 1'b0;
            r_misalign   <= 1'b0;
            r_bus_err    <= 1'b0;
            r_ld_data    <= 32'd0;
            r_ld_sext_op <= 2'b00;
            r_ld_addr    <= 2'b00;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_lat_we     <= w_lat_we_nxt;
            r_lat_size   <= w_lat_size_nxt;
            r_lat_lo     <= w_lat_lo_nxt;
            r_bus_req    <= w_bus_req_nxt;
            r_bus_we     <= w_bus_we_nxt;
            r_bus_wstrb  <= w_bus_wstrb_nxt;
            r_bus_addr   <= w_bus_addr_nxt;
            r_bus_wdata  <= w_bus_wdata_nxt;
            r_done       <= w_done_nxt;
            r_misalign   <= w_misalign_nxt;
            r_bus_err    <= w_bus_err_nxt;
            r_ld_data    <= w_ld_data_nxt;
            r_ld_sext_op <= w_ld_sext_op_nxt;
            r_ld_addr    <= w_ld_addr_nxt;
        end
    end

    // Stall is combinational so the pipeline freezes in the acceptance cycle.
    assign mif.stall = ~rst & (((r_state == c_st_idle) & mif.mem_req & w_aligned) |
                               (r_state == c_st_access));

    assign mif.bus_req    = r_bus_req;
    assign mif.bus_we     = r_bus_we;
    assign mif.bus_wstrb  = r_bus_wstrb;
    assign mif.bus_addr   = r_bus_addr;
    assign mif.bus_wdata  = r_bus_wdata;
    assign mif.done       = r_done;
    assign mif.misalign   = r_misalign;
    assign mif.bus_err    = r_bus_err;
    assign mif.ld_data    = r_ld_data;
    assign mif.ld_sext_op = r_ld_sext_op;
    assign mif.ld_addr    = r_ld_addr;

endmodule
`default_nettype wire

// File: tb/tb_my_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_my_mem_ctrl
// Description : Directed self-checking bench for my_mem_ctrl (TIMEOUT = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_my_mem_ctrl;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_pass;
    int   n_fail;

    my_mem_ctrl_if bif ();

    my_mem_ctrl #(.TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .mif (bif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Writeback-stage sign extender model
    function automatic logic [31:0] sext(input logic [31:0] d, input logic [1:0] op,
                                         input logic [1:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(d >> (8 * a));
        h = a[1] ? d[31:16] : d[15:0];
        case (op)
            2'b01:   return {{24{b[7]}}, b};
            2'b10:   return {{16{h[15]}}, h};
            default: return d;
        endcase
    endfunction

    task automatic req(input logic we, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd);
        bif.mem_req   = 1'b1;
        bif.mem_we    = we;
        bif.mem_size  = sz;
        bif.mem_addr  = a;
        bif.mem_wdata = wd;
    endtask

    initial begin
        n_chk = 0; n_pass = 0; n_fail = 0;
        rst = 1'b1;
        bif.bus_ack = 1'b0;
        bif.bus_rdata = 32'd0;
        req(1'b0, 2'b10, 32'h100, 32'd0);
        #2;
        chk("rst_stall", bif.stall, 0);
        chk("rst_bus_req", bif.bus_req, 0);
        chk("rst_bus_addr", bif.bus_addr, 0);
        chk("rst_wstrb", bif.bus_wstrb, 0);
        chk("rst_ld_data", bif.ld_data, 0);
        chk("rst_done", bif.done, 0);
        bif.mem_req = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();

        // Word load at 0x100, ack in the first ACCESS cycle
        req(1'b0, 2'b10, 32'h100, 32'd0);
        #1 chk("wl_stall_n", bif.stall, 1);
        tick();
        chk("wl_bus_req", bif.bus_req, 1);
        chk("wl_bus_addr", bif.bus_addr, 32'h100);
        chk("wl_wstrb", bif.bus_wstrb, 4'b0000);
        chk("wl_bus_we", bif.bus_we, 0);
        chk("wl_stall_n1", bif.stall, 1);
        bif.bus_ack = 1'b1; bif.bus_rdata = 32'h8000_00F0;
        tick();
        bif.bus_ack = 1'b0; bif.mem_req = 1'b0;
        #1;
        chk("wl_done", bif.done, 1);
        chk("wl_bus_req_resp", bif.bus_req, 0);
        chk("wl_ld_data", bif.ld_data, 32'h8000_00F0);
        chk("wl_sext_op", bif.ld_sext_op, 2'b00);
        chk("wl_stall_resp", bif.stall, 0);
        tick();
        chk("wl_done_off", bif.done, 0);

        // Byte store at 0x203, ack after 3 wait cycles
        req(1'b1, 2'b00, 32'h203, 32'h1234_56AB);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("bs_bus_req", bif.bus_req, 1);
            chk("bs_bus_we", bif.bus_we, 1);
            chk("bs_bus_addr", bif.bus_addr, 32'h200);
            chk("bs_wstrb", bif.bus_wstrb, 4'b1000);
            chk("bs_wdata", bif.bus_wdata, 32'hABAB_ABAB);
            chk("bs_done_wait", bif.done, 0);
            if (i == 3) bif.bus_ack = 1'b1;
            tick();
        end
        bif.bus_ack = 1'b0; bif.mem_req = 1'b0;
        #1;
        chk("bs_done", bif.done, 1);
        chk("bs_ld_data_kept", bif.ld_data, 32'h8000_00F0);
        chk("bs_bus_req_resp", bif.bus_req, 0);
        tick();
        chk("bs_done_once", bif.done, 0);

        // Half load at 0x302
        req(1'b0, 2'b01, 32'h302, 32'd0);
        tick();
        bif.bus_ack = 1'b1; bif.bus_rdata = 32'hFFEE_1122;
        tick();
        bif.bus_ack = 1'b0; bif.mem_req = 1'b0;
        #1;
        chk("hl_done", bif.done, 1);
        chk("hl_sext_op", bif.ld_sext_op, 2'b10);
        chk("hl_ld_addr", bif.ld_addr, 2'b10);
        chk("hl_ld_data", bif.ld_data, 32'hFFEE_1122);
        chk("hl_extended", sext(bif.ld_data, bif.ld_sext_op, bif.ld_addr), 32'hFFFF_FFEE);
        tick();

        // Misaligned half at 0x401 then word at 0x402
        req(1'b0, 2'b01, 32'h401, 32'd0);
        #1 chk("mh_stall", bif.stall, 0);
        tick();
        chk("mh_misalign", bif.misalign, 1);
        chk("mh_bus_req", bif.bus_req, 0);
        bif.mem_req = 1'b0;
        tick();
        chk("mh_misalign_off", bif.misalign, 0);
        req(1'b0, 2'b10, 32'h402, 32'd0);
        #1 chk("mw_stall", bif.stall, 0);
        tick();
        chk("mw_misalign", bif.misalign, 1);
        chk("mw_bus_req", bif.bus_req, 0);
        bif.mem_req = 1'b0;
        tick();
        chk("mw_misalign_off", bif.misalign, 0);
        chk("mw_bus_req_off", bif.bus_req, 0);

        // Timeout with no ack
        req(1'b0, 2'b10, 32'h500, 32'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("to_bus_req", bif.bus_req, 1);
            chk("to_bus_err_early", bif.bus_err, 0);
            tick();
        end
        bif.mem_req = 1'b0;
        #1;
        chk("to_bus_req_drop", bif.bus_req, 0);
        chk("to_bus_err", bif.bus_err, 1);
        chk("to_no_done", bif.done, 0);
        tick();
        chk("to_bus_err_once", bif.bus_err, 0);
        chk("to_no_done_late", bif.done, 0);
        req(1'b1, 2'b10, 32'h600, 32'hCAFE_F00D);
        tick();
        chk("to_next_req", bif.bus_req, 1);
        chk("to_next_wstrb", bif.bus_wstrb, 4'b1111);
        chk("to_next_wdata", bif.bus_wdata, 32'hCAFE_F00D);
        bif.bus_ack = 1'b1;
        tick();
        bif.bus_ack = 1'b0; bif.mem_req = 1'b0;
        #1 chk("to_next_done", bif.done, 1);
        tick();

        // Reset during the second ACCESS cycle
        req(1'b0, 2'b00, 32'h701, 32'd0);
        tick();
        chk("rm_bus_req", bif.bus_req, 1);
        tick();
        rst = 1'b1;
        #1;
        chk("rm_bus_req_rst", bif.bus_req, 0);
        chk("rm_bus_addr_rst", bif.bus_addr, 0);
        chk("rm_ld_data_rst", bif.ld_data, 0);
        chk("rm_sext_op_rst", bif.ld_sext_op, 0);
        chk("rm_stall_rst", bif.stall, 0);
        bif.mem_req = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        bif.bus_ack = 1'b1;
        tick();
        bif.bus_ack = 1'b0;
        chk("rm_stray_ack_done", bif.done, 0);
        chk("rm_stray_ack_req", bif.bus_req, 0);
        tick();
        chk("rm_stray_ack_done2", bif.done, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
